// File: rtl/reset_toggle_gen.sv
// Multi-channel reset/stimulus toggle generator: each enabled channel starts at a
// programmed level and inverts every half_period cycles for num_toggles toggles.
module reset_toggle_gen #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           stop,
    input  logic [CW-1:0]  half_period,
    input  logic [CW-1:0]  num_toggles,
    input  logic [NCH-1:0] ch_en,
    input  logic [NCH-1:0] init_level,
    output logic [NCH-1:0] out,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  toggle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [1:0]     rst_sync;
    logic           armed;
    logic [CW-1:0]  pcnt, pcnt_n;
    logic [CW-1:0]  hp_q, hp_n;
    logic [CW-1:0]  nt_q, nt_n;
    logic [NCH-1:0] en_q, en_n;
    logic [NCH-1:0] out_n;
    logic [CW-1:0]  tcnt_n;
    logic           busy_n, done_n;

    // Reset release is retimed through two flops; starts are ignored until it completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign armed = rst_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            out        <= '1;
            busy       <= 1'b0;
            done       <= 1'b0;
            toggle_cnt <= '0;
            pcnt       <= '0;
            hp_q       <= CW'(1);
            nt_q       <= '0;
            en_q       <= '0;
        end else begin
            state      <= state_n;
            out        <= out_n;
            busy       <= busy_n;
            done       <= done_n;
            toggle_cnt <= tcnt_n;
            pcnt       <= pcnt_n;
            hp_q       <= hp_n;
            nt_q       <= nt_n;
            en_q       <= en_n;
        end
    end

    always_comb begin
        state_n = state;
        out_n   = out;
        tcnt_n  = toggle_cnt;
        pcnt_n  = pcnt;
        hp_n    = hp_q;
        nt_n    = nt_q;
        en_n    = en_q;

        unique case (state)
            IDLE: begin
                if (armed && start && !stop) begin
                    state_n = RUN;
                    hp_n    = (half_period == '0) ? CW'(1) : half_period;
                    nt_n    = num_toggles;
                    en_n    = ch_en;
                    out_n   = init_level;
                    pcnt_n  = '0;
                    tcnt_n  = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (pcnt == hp_q - CW'(1)) begin
                    pcnt_n = '0;
                    out_n  = out ^ en_q;
                    tcnt_n = toggle_cnt + CW'(1);
                    // num_toggles of zero means free-run; the count simply wraps
                    if (nt_q != '0 && tcnt_n == nt_q) begin
                        state_n = DONE;
                    end
                end else begin
                    pcnt_n = pcnt + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
    end

endmodule
